minterm_scanner: RTL and testbench
==================================

Name: minterm_scanner

Overview:
- Sequential truth-table extractor and checker for the team's combinational SOP blocks (4-input Boolean function units).
- Drives every input vector 0..2^N_IN-1 onto a function-under-test and waits a settle interval. Then samples the 1-bit output and assembles the captured truth table as a minterm mask.
- Compares the captured mask against an expected mask and reports the mismatch count plus pass/fail.
- Sits in self-test and bring-up logic, beside the combinational function blocks.

Parameters:
- N_IN, 4: number of function inputs; mask width is 2^N_IN.
- SETTLE, 1: cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a scan; accepted only in IDLE.
- exp_mask  input  2^N_IN  expected truth table; bit i = F(vector i); latched on start accept.
- vec  output  N_IN  vector driven to the function-under-test; bit N_IN-1 = first variable (A).
- f_in  input  1  output of the function-under-test.
- busy  output  1  high from the cycle after start accept through the DONE cycle.
- done  output  1  one-cycle pulse in the DONE state.
- tt  output  2^N_IN  captured truth table.
- err_cnt  output  N_IN+1  number of mismatching minterms, 0..2^N_IN.
- pass  output  1  high when err_cnt==0; valid from done and held afterwards.

Behaviour:
- Reset values (async, immediate): state=IDLE, vec=0, busy=0, done=0, tt=0, err_cnt=0, pass=0, settle counter=0, latched mask=0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - On start=1, latch exp_mask and clear vec, tt, err_cnt and pass.
  - Go to DRIVE, with busy=1 from the next cycle.
- DRIVE:
  - vec is held stable.
  - The settle counter counts up to SETTLE-1, then the FSM goes to SAMPLE.
  - The DRIVE interval is exactly SETTLE cycles.
- SAMPLE, one cycle:
  - tt[vec] <= f_in.
  - If f_in != latched_mask[vec], err_cnt increments.
  - If vec == 2^N_IN-1, go to DONE; otherwise vec increments and the FSM returns to DRIVE.
- DONE, one cycle:
  - done=1.
  - pass is driven from the final err_cnt.
  - Go to IDLE; busy=0 from the next cycle.
- Latency: start accepted at edge k gives done=1 in cycle k+1+2^N_IN*(SETTLE+1). With defaults this is k+33.
- start while busy is ignored, with no queuing. start held high in the DONE cycle is not seen; it is accepted in the following IDLE cycle.
- exp_mask changes mid-scan have no effect.
- err_cnt cannot wrap: its width is sized for all 2^N_IN mismatches.
- vec does not wrap within a scan; it returns to 0 only on the next start accept.
- tt, err_cnt and pass hold their values in IDLE until the next start accept.
- rst mid-scan aborts immediately to the reset values. No done pulse is issued.

Optional Feature:
- Macro: MINTERM_SCANNER_FIRST_ERR_EN.
- Defined:
  - Adds ports first_err_idx (output, N_IN) and first_err_vld (output, 1).
  - On the first mismatching SAMPLE of a scan, first_err_idx captures vec and first_err_vld sets.
  - Both clear on start accept and on rst.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package minterm_scan_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, DONE);
  - the localparam for mask width (1<<N_IN) and the err_cnt width rule;
  - the SETTLE legal-range constant.
- One sub-module, scan_settle_ctr: a settle counter with load/clear and a terminal-count flag. The FSM and capture logic stay in the top module.

Test Plan:
1. Bench model F = minterms {0,2,5,7,8,10,12,13}, exp_mask=16'h35A5, defaults -> done at k+33, tt=16'h35A5, err_cnt=0, pass=1.
2. Same function, exp_mask=16'h35A4 -> tt=16'h35A5, err_cnt=1, pass=0. With FIRST_ERR_EN: first_err_idx=0, first_err_vld=1.
3. f_in tied 1, exp_mask=16'h0000 -> err_cnt=16 (5'b10000, no wrap), tt=16'hFFFF, pass=0.
4. SETTLE=3, mask 16'h35A5 -> vec holds each value 3 cycles; done at k+65. Start pulses at cycles k+5 and k+20 are ignored.
5. Assert rst at cycle k+10 mid-scan -> next cycle busy=0, vec=0, tt=0, err_cnt=0, no done pulse. A new start then completes normally.
6. Back-to-back: start held high continuously -> second scan accepted the cycle after DONE. tt and err_cnt clear at that accept; done pulses exactly once per scan.

Source files
------------

// File: rtl/minterm_scanner_pkg.sv
// minterm_scan_pkg: state encoding, sizing rules and SETTLE bounds shared by minterm_scanner.
package minterm_scan_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    localparam int N_IN_DEF   = 4;
    localparam int MASK_W_DEF = 1 << N_IN_DEF;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;
    localparam int CTR_W      = 4;
    function automatic int mask_w(input int n);
        return 1 << n;
    endfunction
    // One extra bit so a fully mismatching table (2^n errors) cannot wrap.
    function automatic int cnt_w(input int n);
        return n + 1;
    endfunction
endpackage

// File: rtl/scan_settle_ctr.sv
// scan_settle_ctr: settle-interval counter with clear, increment and terminal-count flag.
module scan_settle_ctr
    import minterm_scan_pkg::*;
#(
    parameter int W = CTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         tc
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    assign tc = cnt == term;
endmodule

// File: rtl/minterm_scanner.sv
// minterm_scanner: walks all input vectors of a function-under-test, captures its truth table and counts mismatches.
// Optional first-mismatch capture ports enabled by MINTERM_SCANNER_FIRST_ERR_EN.
module minterm_scanner
    import minterm_scan_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1,
    localparam int MW    = mask_w(N_IN),
    localparam int CW    = cnt_w(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [MW-1:0]   exp_mask,
    output logic [N_IN-1:0] vec,
    input  logic            f_in,
    output logic            busy,
    output logic            done,
    output logic [MW-1:0]   tt,
    output logic [CW-1:0]   err_cnt,
    output logic            pass
`ifdef MINTERM_SCANNER_FIRST_ERR_EN
    ,
    output logic [N_IN-1:0] first_err_idx,
    output logic            first_err_vld
`endif
);
    if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("minterm_scanner: SETTLE out of range");
    end

    state_t state, state_nxt;
    logic [MW-1:0] exp_q;
    logic [CW-1:0] err_nxt;
    logic tc, mism, last, accept;

    assign accept  = state == IDLE && start;
    assign mism    = f_in != exp_q[vec];
    assign last    = &vec;
    assign err_nxt = err_cnt + CW'(mism);
    assign busy    = state != IDLE;
    assign done    = state == DONE;

    // Held clear outside DRIVE so every vector starts its settle interval from zero.
    scan_settle_ctr #(.W(CTR_W)) u_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != DRIVE || tc),
        .inc  (state == DRIVE),
        .term (CTR_W'(SETTLE - 1)),
        .tc   (tc)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? DRIVE : IDLE;
            DRIVE:   state_nxt = tc ? SAMPLE : DRIVE;
            SAMPLE:  state_nxt = last ? DONE : DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // pass is resolved on the final sample so it is already valid in the DONE cycle.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            vec     <= '0;
            tt      <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
            exp_q   <= '0;
        end else if (accept) begin
            vec     <= '0;
            tt      <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
            exp_q   <= exp_mask;
        end else if (state == SAMPLE) begin
            tt[vec] <= f_in;
            err_cnt <= err_nxt;
            if (last) pass <= err_nxt == '0;
            else vec <= vec + 1'b1;
        end

`ifdef MINTERM_SCANNER_FIRST_ERR_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if (accept) begin
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if (state == SAMPLE && mism && !first_err_vld) begin
            first_err_idx <= vec;
            first_err_vld <= 1'b1;
        end
`endif
endmodule

// File: tb/tb_minterm_scanner.sv
// tb_minterm_scanner: directed checks of minterm_scanner with SETTLE=1 (u0) and SETTLE=3 (u3) instances.
`timescale 1ns/1ps
module tb_minterm_scanner;
    logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start3 = 1'b0, fmode = 1'b0, sel = 1'b0;
    logic [15:0] exp_mask = '0;
    logic [15:0] fmask = 16'h35A5;
    logic [3:0] vec0, vec3, d_vec;
    logic busy0, busy3, done0, done3, pass0, pass3, f0, f3;
    logic d_busy, d_done, d_pass;
    logic [15:0] tt0, tt3, d_tt;
    logic [4:0] err0, err3, d_err;
    int checks = 0, errors = 0, nd0 = 0, lat;
`ifdef MINTERM_SCANNER_FIRST_ERR_EN
    logic [3:0] fei0, fei3;
    logic fev0, fev3;
`endif

    always #5 clk = ~clk;

    // Function model: minterms {0,2,5,7,8,10,12,13}; fmode forces constant 1.
    assign f0 = fmode | fmask[vec0];
    assign f3 = fmask[vec3];

    assign d_vec  = sel ? vec3 : vec0;
    assign d_busy = sel ? busy3 : busy0;
    assign d_done = sel ? done3 : done0;
    assign d_pass = sel ? pass3 : pass0;
    assign d_tt   = sel ? tt3 : tt0;
    assign d_err  = sel ? err3 : err0;

    minterm_scanner u0 (
        .clk(clk), .rst(rst), .start(start0), .exp_mask(exp_mask), .vec(vec0), .f_in(f0),
        .busy(busy0), .done(done0), .tt(tt0), .err_cnt(err0), .pass(pass0)
`ifdef MINTERM_SCANNER_FIRST_ERR_EN
        , .first_err_idx(fei0), .first_err_vld(fev0)
`endif
    );

    minterm_scanner #(.SETTLE(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .exp_mask(exp_mask), .vec(vec3), .f_in(f3),
        .busy(busy3), .done(done3), .tt(tt3), .err_cnt(err3), .pass(pass3)
`ifdef MINTERM_SCANNER_FIRST_ERR_EN
        , .first_err_idx(fei3), .first_err_vld(fev3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (done0) nd0++;
    endtask

    // lat numbers cycles from the accept: cycle 1 is the first cycle after the accepting edge.
    task automatic wait_done(output int l);
        l = 1;
        while (!d_done && l < 200) begin
            if (sel) begin
                start3 = (l == 5 || l == 20);
                if (l == 3 || l == 4) chk("s3_vec_hold", d_vec, 0);
                if (l == 5) chk("s3_vec_step", d_vec, 1);
            end
            tick;
            l++;
        end
        start3 = 1'b0;
    endtask

    task automatic scan(input bit s, input logic [15:0] m, input int elat, input logic [15:0] ett,
                        input logic [4:0] eerr, input logic epass, input string tag);
        int l;
        sel = s;
        exp_mask = m;
        if (s) start3 = 1'b1;
        else start0 = 1'b1;
        tick;
        start0 = 1'b0;
        start3 = 1'b0;
        exp_mask = ~m;
        chk({tag, "_busy"}, d_busy, 1);
        chk({tag, "_tt_clr"}, d_tt, 0);
        wait_done(l);
        chk({tag, "_lat"}, l, elat);
        chk({tag, "_tt"}, d_tt, ett);
        chk({tag, "_err"}, d_err, eerr);
        chk({tag, "_pass"}, d_pass, epass);
        tick;
        chk({tag, "_done_pulse"}, d_done, 0);
        chk({tag, "_idle_busy"}, d_busy, 0);
        chk({tag, "_tt_hold"}, d_tt, ett);
        chk({tag, "_pass_hold"}, d_pass, epass);
    endtask

    initial begin
        repeat (2) tick;
        chk("rst_busy", busy0, 0);
        chk("rst_vec", vec0, 0);
        chk("rst_tt", tt0, 0);
        chk("rst_err", err0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_done", done0, 0);
        rst = 1'b0;
        tick;

        scan(1'b0, 16'h35A5, 33, 16'h35A5, 5'd0, 1'b1, "t1");
        scan(1'b0, 16'h35A4, 33, 16'h35A5, 5'd1, 1'b0, "t2");
`ifdef MINTERM_SCANNER_FIRST_ERR_EN
        chk("t2_fe_idx", fei0, 0);
        chk("t2_fe_vld", fev0, 1);
`endif
        fmode = 1'b1;
        scan(1'b0, 16'h0000, 33, 16'hFFFF, 5'd16, 1'b0, "t3");
        fmode = 1'b0;
        scan(1'b1, 16'h35A5, 65, 16'h35A5, 5'd0, 1'b1, "t4");

        sel = 1'b0;
        exp_mask = 16'h35A4;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        repeat (9) tick;
        chk("t5_vec_pre", vec0, 4);
        chk("t5_tt_pre", tt0, 16'h0005);
        chk("t5_err_pre", err0, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy0, 0);
        chk("t5_rst_vec", vec0, 0);
        chk("t5_rst_tt", tt0, 0);
        chk("t5_rst_err", err0, 0);
        chk("t5_rst_done", done0, 0);
        tick;
        rst = 1'b0;
        nd0 = 0;
        repeat (40) tick;
        chk("t5_no_done", nd0, 0);
        scan(1'b0, 16'h35B5, 33, 16'h35A5, 5'd1, 1'b0, "t5b");
`ifdef MINTERM_SCANNER_FIRST_ERR_EN
        chk("t5b_fe_idx", fei0, 4);
        chk("t5b_fe_vld", fev0, 1);
`endif

        sel = 1'b0;
        exp_mask = 16'h35A4;
        nd0 = 0;
        start0 = 1'b1;
        tick;
        wait_done(lat);
        chk("t6_lat1", lat, 33);
        chk("t6_err1", err0, 1);
        tick;
        chk("t6_gap_busy", busy0, 0);
        chk("t6_gap_err", err0, 1);
        tick;
        chk("t6_acc_busy", busy0, 1);
        chk("t6_acc_tt", tt0, 0);
        chk("t6_acc_err", err0, 0);
        wait_done(lat);
        chk("t6_lat2", lat, 33);
        chk("t6_tt2", tt0, 16'h35A5);
        chk("t6_err2", err0, 1);
        start0 = 1'b0;
        repeat (3) tick;
        chk("t6_done_count", nd0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
